// File: rtl/grid_renderer_pkg.sv
// Shared grid geometry, colour constants and render FSM encoding.
// The grid controller and VGA top import the same values.
package grid_renderer_pkg;

  localparam int GRID_WIDTH  = 160;
  localparam int GRID_HEIGHT = 120;
  localparam int PLAYER_ROW  = 119;

  localparam logic [2:0] COLOUR_BULLET = 3'b111;
  localparam logic [2:0] COLOUR_BG     = 3'b000;
  localparam logic [2:0] COLOUR_PLAYER = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } render_state_t;

endpackage

// File: rtl/grid_renderer_scan_counter.sv
// Column-major x/y pixel counter. y is the inner index and x the outer one.
// last flags the final pixel of the frame.
module grid_renderer_scan_counter
  import grid_renderer_pkg::*;
#(
  parameter int WIDTH  = GRID_WIDTH,
  parameter int HEIGHT = GRID_HEIGHT
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       clear,
  input  logic       advance,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic       last
);

  logic y_wrap;

  assign y_wrap = (y == 7'(HEIGHT - 1));
  assign last   = y_wrap && (x == 8'(WIDTH - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      x <= '0;
      y <= '0;
    end else if (clear) begin
      x <= '0;
      y <= '0;
    end else if (advance) begin
      if (y_wrap) begin
        y <= '0;
        x <= last ? 8'd0 : x + 8'd1;
      end else begin
        y <= y + 7'd1;
      end
    end
  end

endmodule

// File: rtl/grid_renderer.sv
// Snapshots the bullet grid on start and streams it to the framebuffer,
// one registered pixel write per clock, in column-major order.
module grid_renderer
  import grid_renderer_pkg::*;
#(
  parameter int         WIDTH         = GRID_WIDTH,
  parameter int         HEIGHT        = GRID_HEIGHT,
  parameter logic [2:0] BULLET_COLOUR = COLOUR_BULLET,
  parameter logic [2:0] BG_COLOUR     = COLOUR_BG,
  parameter logic [2:0] PLAYER_COLOUR = COLOUR_PLAYER,
  parameter int         PLAYER_Y      = PLAYER_ROW
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      start,
  input  logic [WIDTH*HEIGHT-1:0]   grid,
  input  logic [7:0]                user_x,
  output logic [7:0]                x,
  output logic [6:0]                y,
  output logic [2:0]                colour,
  output logic                      plot,
  output logic                      busy,
  output logic                      done
);

  localparam int NBITS = WIDTH * HEIGHT;

  render_state_t     state;
  logic [NBITS-1:0]  snap;
  logic [7:0]        px;
  logic [7:0]        cnt_x;
  logic [6:0]        cnt_y;
  logic              cnt_last;
  logic              cnt_clear;
  logic              cnt_advance;
  logic [2:0]        pix_colour;

  assign cnt_clear   = (state == ST_IDLE) && start;
  assign cnt_advance = (state == ST_SCAN);

  grid_renderer_scan_counter #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT)
  ) u_scan_counter (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (cnt_clear),
    .advance (cnt_advance),
    .x       (cnt_x),
    .y       (cnt_y),
    .last    (cnt_last)
  );

  // Scan order matches grid bit order, so snap[0] is always the current pixel.
  always_comb begin
    pix_colour = BG_COLOUR;
    if ((cnt_x == px) && (cnt_y == 7'(PLAYER_Y)))
      pix_colour = PLAYER_COLOUR;
    else if (snap[0])
      pix_colour = BULLET_COLOUR;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state  <= ST_IDLE;
      snap   <= '0;
      px     <= '0;
      x      <= '0;
      y      <= '0;
      colour <= BG_COLOUR;
      plot   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      plot <= 1'b0;
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            snap  <= grid;
            px    <= user_x;
            busy  <= 1'b1;
            state <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          x      <= cnt_x;
          y      <= cnt_y;
          colour <= pix_colour;
          plot   <= 1'b1;
          snap   <= {1'b0, snap[NBITS-1:1]};
          if (cnt_last)
            state <= ST_DONE;
        end
        ST_DONE: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_grid_renderer.sv
// Scoreboard bench for grid_renderer: expected pixels are queued at each
// accepted start edge and popped as plot writes appear.
module tb_grid_renderer;

  localparam int W = 160;
  localparam int H = 120;
  localparam int N = W * H;

  logic         clock;
  logic         reset_n;
  logic         start;
  logic [N-1:0] grid_in;
  logic [7:0]   user_x_in;
  logic [7:0]   x;
  logic [6:0]   y;
  logic [2:0]   colour;
  logic         plot;
  logic         busy;
  logic         done;

  int total;
  int bad;
  logic [17:0] sb[$];

  grid_renderer dut (
    .clock   (clock),
    .reset_n (reset_n),
    .start   (start),
    .grid    (grid_in),
    .user_x  (user_x_in),
    .x       (x),
    .y       (y),
    .colour  (colour),
    .plot    (plot),
    .busy    (busy),
    .done    (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model of one frame, built from the stimulus captured at the start edge.
  task automatic pushExpected(input logic [N-1:0] g, input logic [7:0] ux);
    logic [2:0] col;
    for (int xx = 0; xx < W; xx++) begin
      for (int yy = 0; yy < H; yy++) begin
        if ((xx == int'(ux)) && (yy == 119)) col = 3'b010;
        else if (g[H*xx + yy])              col = 3'b111;
        else                                col = 3'b000;
        sb.push_back({8'(xx), 7'(yy), col});
      end
    end
  endtask

  always @(negedge clock) begin
    if (plot) begin
      if (sb.size() == 0)
        checkOutput("unexpected_plot", 32'(plot), 32'd0);
      else
        checkOutput("pixel_xyc", 32'({x, y, colour}), 32'(sb.pop_front()));
    end
  end

  // Runs one frame; with hold_start the start line stays high through the
  // whole frame and the following IDLE edge, chaining a second frame.
  task automatic applyStimulus(input logic [N-1:0] g, input logic [7:0] ux,
                               input bit hold_start, input int toggle_at);
    grid_in   = g;
    user_x_in = ux;
    start     = 1'b1;
    @(posedge clock);
    pushExpected(g, ux);
    #1;
    if (!hold_start) start = 1'b0;
    checkOutput("busy_after_start", 32'(busy), 32'd1);
    checkOutput("plot_after_start", 32'(plot), 32'd0);
    for (int k = 1; k <= N; k++) begin
      @(posedge clock);
      #1;
      if (k == toggle_at) grid_in = '1;
      if (k == 1) checkOutput("busy_first_pixel", 32'(busy), 32'd1);
      if (k == N) begin
        checkOutput("busy_last_pixel", 32'(busy), 32'd1);
        checkOutput("done_last_pixel", 32'(done), 32'd0);
      end
    end
    @(posedge clock);
    #1;
    checkOutput("done_pulse", 32'(done), 32'd1);
    checkOutput("plot_in_done", 32'(plot), 32'd0);
    checkOutput("busy_in_done", 32'(busy), 32'd0);
    checkOutput("queue_drained", 32'(sb.size()), 32'd0);
    @(posedge clock);
    if (hold_start) pushExpected(grid_in, user_x_in);
    #1;
    checkOutput("done_cleared", 32'(done), 32'd0);
    checkOutput("busy_next", 32'(busy), hold_start ? 32'd1 : 32'd0);
    start = 1'b0;
  endtask

  // Drops reset partway through a frame already in progress.
  task automatic resetMidScan();
    for (int k = 1; k <= 1000; k++) begin
      @(posedge clock);
      #1;
    end
    checkOutput("plot_before_reset", 32'(plot), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("reset_plot", 32'(plot), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_xy", 32'({x, y}), 32'd0);
    checkOutput("reset_colour", 32'(colour), 32'd0);
    sb.delete();
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    checkOutput("idle_after_reset", 32'({plot, busy, done}), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [N-1:0] g;
    total     = 0;
    bad       = 0;
    start     = 1'b0;
    grid_in   = '0;
    user_x_in = 8'd0;
    reset_n   = 1'b1;
    #2 reset_n = 1'b0;
    #10;
    checkOutput("rst_x", 32'(x), 32'd0);
    checkOutput("rst_y", 32'(y), 32'd0);
    checkOutput("rst_colour", 32'(colour), 32'd0);
    checkOutput("rst_plot", 32'(plot), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    // Empty grid, player off-screen.
    applyStimulus('0, 8'd200, 1'b0, 0);

    // Single bullet at (5,7), bullet under player at (80,119), grid torn mid-scan,
    // start held so the next frame chains on the first IDLE edge.
    g = '0;
    g[H*5 + 7]    = 1'b1;
    g[H*80 + 119] = 1'b1;
    applyStimulus(g, 8'd80, 1'b1, 500);

    resetMidScan();

    // Restart after reset begins again at (0,0).
    g = '0;
    g[0] = 1'b1;
    applyStimulus(g, 8'd0, 1'b0, 0);
    checkOutput("queue_final", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
